vga_sync_counter_core: RTL
==========================

Name: vga_sync_counter_core

Overview:
- Source end of the video pixel pipeline: generates the pixel tick, the x/y frame-counter coordinates, and the hsync/vsync/video_on timing that every sprite and overlay core in the chain consumes.
- Also serves as the CPU's readback slot: the video slot interface here is readable (position, frame count, status), not write-only.
- Sits first in the video stream chain. Its x/y outputs fan out to all downstream stream cores.

Parameters:
- HD, 640, horizontal display pixels
- HF, 16, horizontal front porch
- HB, 48, horizontal back porch
- HR, 96, horizontal retrace (hsync) width
- VD, 480, vertical display lines
- VF, 10, vertical front porch
- VB, 33, vertical back porch
- VR, 2, vertical retrace (vsync) width
- DIV, 4, system clocks per pixel

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cs  in  1  video slot chip select
- read  in  1  slot read strobe
- write  in  1  slot write strobe
- addr  in  14  slot address; addr[1:0] selects register
- wr_data  in  32  slot write data
- rd_data  out  32  slot read data
- x  out  11  current pixel column, 0..HT-1
- y  out  11  current line, 0..VT-1
- p_tick  out  1  one-clk pulse per pixel
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high when x<HD and y<VD
- frame_start  out  1  one-clk pulse at start of each frame

Behaviour:
- Derived constants: HT=HD+HF+HB+HR=800, VT=VD+VF+VB+VR=525.
- Reset (reset=0, async): div_cnt=0, x=0, y=0, frame_cnt=0, run=1, hsync=1, vsync=1, p_tick=0, frame_start=0.
- Divider:
  - When run=1, div_cnt counts 0..DIV-1 and wraps.
  - p_tick=1 exactly when run=1 and div_cnt==DIV-1 (combinational from div_cnt).
- Horizontal counter: on each p_tick, x increments; at x==HT-1 it wraps to 0.
- Vertical counter: y increments only on a p_tick where x wraps; at y==VT-1 it wraps to 0.
- Frame boundary:
  - frame_start=1 for the single clk of the p_tick where x==HT-1 and y==VT-1 (combinational).
  - frame_cnt (32-bit) increments on that same edge and wraps 0xFFFFFFFF to 0.
- hsync and vsync are registered, updated on p_tick edges, and track the post-increment counter values:
  - hsync=0 when next x in [HD+HF, HD+HF+HR-1] = 656..751.
  - vsync=0 when next y in [VD+VF, VD+VF+VR-1] = 490..491.
- video_on is combinational from x and y.
- run=0: div_cnt, x, y and frame_cnt hold their values; p_tick and frame_start stay 0; sync outputs hold.
- Register map, selected by addr[1:0]; addr[13:2] ignored:
  - 0 read: {5'b0, y, 5'b0, x}, live value
  - 1 read: frame_cnt
  - 2 read: {28'b0, run, vsync, hsync, video_on}
  - 3 read: {30'b0, 1'b0, run}
  - 3 write: wr_data[0] loads run; wr_data[1]=1 clears frame_cnt to 0 (self-clearing, reads 0)
  - Writes to 0..2 are ignored.
- rd_data is a combinational mux, valid in the same cycle as cs&read. rd_data=0 when cs&read is false.
- Collisions:
  - A clear and a frame-wrap increment in the same clk: clear wins, frame_cnt=0.
  - A write to run and a p_tick in the same clk: that p_tick still takes effect; the new run value applies from the next clk.
- Reset asserted mid-line: all state returns to reset values immediately. After release, counting restarts at x=0, y=0 with div_cnt=0.

Test Plan:
- Release reset, DIV=4: p_tick every 4th clk; x reaches 799 then wraps to 0; y increments 0→1 on the same edge.
- Run 800 pixels per line: hsync low for exactly 96 p_ticks, covering x=656..751. video_on=0 for x≥640.
- Run a full frame of 800×525 pixels: vsync low on lines 490..491; frame_start pulses once, for one clk, at x=799/y=524; reg 1 reads 1.
- Write reg3=0 at x=100: x holds at 100 for 1000 clks; reg0 reads 0x00000064 (y=0). Write reg3=1: counting resumes at 101.
- Write reg3=0x3 on the frame-wrap clk: frame_cnt reads 0, run stays 1, x/y wrap to 0 normally.
- Assert reset=0 for 1 clk at x=300, y=200: x=y=0, hsync=vsync=1, frame_cnt=0 immediately; reg3 reads 1.

Source files
------------

// File: rtl/vga_sync_counter_core.sv
// VGA timing source: pixel-tick divider, x/y frame counters, registered sync outputs
// and a readable CPU slot exposing position, frame count, status and the run control.
module vga_sync_counter_core #(
    parameter int HD  = 640,
    parameter int HF  = 16,
    parameter int HB  = 48,
    parameter int HR  = 96,
    parameter int VD  = 480,
    parameter int VF  = 10,
    parameter int VB  = 33,
    parameter int VR  = 2,
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [13:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        p_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start
);

    localparam int HT = HD + HF + HB + HR;
    localparam int VT = VD + VF + VB + VR;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
    localparam logic [10:0]   HT_M1  = 11'(HT - 1);
    localparam logic [10:0]   VT_M1  = 11'(VT - 1);
    localparam logic [10:0]   HS_LO  = 11'(HD + HF);
    localparam logic [10:0]   HS_HI  = 11'(HD + HF + HR - 1);
    localparam logic [10:0]   VS_LO  = 11'(VD + VF);
    localparam logic [10:0]   VS_HI  = 11'(VD + VF + VR - 1);
    localparam logic [10:0]   HD_L   = 11'(HD);
    localparam logic [10:0]   VD_L   = 11'(VD);

    logic [DW-1:0] div_q, div_d;
    logic [10:0]   x_q, x_d, y_q, y_d;
    logic [31:0]   frame_q, frame_d;
    logic          run_q, run_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          x_wrap, y_wrap, ctrl_wr, clr;
    logic          unused_bits;

    assign x_wrap      = (x_q == HT_M1);
    assign y_wrap      = (y_q == VT_M1);
    assign p_tick      = run_q && (div_q == DIV_M1);
    assign frame_start = p_tick && x_wrap && y_wrap;
    assign ctrl_wr     = cs && write && (addr[1:0] == 2'd3);
    assign clr         = ctrl_wr && wr_data[1];
    assign video_on    = (x_q < HD_L) && (y_q < VD_L);
    assign unused_bits = ^{addr[13:2], wr_data[31:2]};

    always_comb begin
        div_d   = div_q;
        x_d     = x_q;
        y_d     = y_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (run_q) begin
            div_d = p_tick ? '0 : div_q + 1'b1;
        end
        // Sync levels are derived from the post-increment position so they line up with x/y.
        if (p_tick) begin
            x_d = x_wrap ? 11'd0 : x_q + 11'd1;
            if (x_wrap) begin
                y_d = y_wrap ? 11'd0 : y_q + 11'd1;
            end
            hsync_d = !((x_d >= HS_LO) && (x_d <= HS_HI));
            vsync_d = !((y_d >= VS_LO) && (y_d <= VS_HI));
        end
    end

    // A clear from the CPU beats a same-cycle frame-wrap increment.
    always_comb begin
        frame_d = frame_q;
        if (clr) begin
            frame_d = '0;
        end else if (frame_start) begin
            frame_d = frame_q + 32'd1;
        end
        run_d = ctrl_wr ? wr_data[0] : run_q;
    end

    always_comb begin
        rd_data = '0;
        if (cs && read) begin
            case (addr[1:0])
                2'd0:    rd_data = {5'b0, y_q, 5'b0, x_q};
                2'd1:    rd_data = frame_q;
                2'd2:    rd_data = {28'b0, run_q, vsync_q, hsync_q, video_on};
                default: rd_data = {31'b0, run_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            run_q   <= 1'b1;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            run_q   <= run_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule
